// File: rtl/gate_pipe_checker_if.sv
// gate_pipe_checker_if: operand/result handshake bundle for gate_pipe_checker.
// master = stimulus/sink side, slave = the checker itself.
interface gate_pipe_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             inj;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] s_nand;
    logic             mismatch;
    logic [15:0]      txn_count;
    logic [CNT_W-1:0] err_count;
    logic             clear;

    modport master (
        output in_valid, a, b, op, inj, out_ready, clear,
        input  in_ready, out_valid, s, s_nand, mismatch,
        input  txn_count, err_count
    );

    modport slave (
        input  in_valid, a, b, op, inj, out_ready, clear,
        output in_ready, out_valid, s, s_nand, mismatch,
        output txn_count, err_count
    );
endinterface

// File: rtl/gate_pipe_checker.sv
// gate_pipe_checker: two-stage pipeline computing 8 bitwise ops via a
// NAND-only network and via operators, comparing both per transaction.
module gate_pipe_checker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    gate_pipe_checker_if.slave bus
);

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_NOTA = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    // Stage 1 (operand) state
    logic             s1_v_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             inj_q;

    // Stage 2 (result) state
    logic             out_v_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] sn_q;
    logic             mis_q;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] sn_d;
    logic             mis_d;

    // Counters
    logic [15:0]      txn_q;
    logic [15:0]      txn_d;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;

    // Handshake terms
    logic s2_ready;
    logic in_ready;
    logic in_hs;
    logic xfer;
    logic out_hs;

    assign s2_ready = !out_v_q || bus.out_ready;
    assign in_ready = !s1_v_q || s2_ready;
    assign in_hs    = bus.in_valid && in_ready;
    assign xfer     = s1_v_q && s2_ready;
    assign out_hs   = out_v_q && bus.out_ready;

    // NAND-only network, one gate slice per bit
    logic [WIDTH-1:0] n_na;
    logic [WIDTH-1:0] n_nb;
    logic [WIDTH-1:0] n_ab;
    logic [WIDTH-1:0] n_or;
    logic [WIDTH-1:0] n_nor;
    logic [WIDTH-1:0] n_and;
    logic [WIDTH-1:0] n_t1;
    logic [WIDTH-1:0] n_t2;
    logic [WIDTH-1:0] n_xor;
    logic [WIDTH-1:0] n_xnor;
    logic [WIDTH-1:0] n_pass;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand u_na   (n_na[i],   a_q[i],   a_q[i]);
        nand u_nb   (n_nb[i],   b_q[i],   b_q[i]);
        nand u_ab   (n_ab[i],   a_q[i],   b_q[i]);
        nand u_or   (n_or[i],   n_na[i],  n_nb[i]);
        nand u_nor  (n_nor[i],  n_or[i],  n_or[i]);
        nand u_and  (n_and[i],  n_ab[i],  n_ab[i]);
        nand u_t1   (n_t1[i],   a_q[i],   n_ab[i]);
        nand u_t2   (n_t2[i],   b_q[i],   n_ab[i]);
        nand u_xor  (n_xor[i],  n_t1[i],  n_t2[i]);
        nand u_xnor (n_xnor[i], n_xor[i], n_xor[i]);
        nand u_pass (n_pass[i], n_na[i],  n_na[i]);
    end

    // Behavioural reference path
    logic [WIDTH-1:0] e_or;
    logic [WIDTH-1:0] e_and;
    logic [WIDTH-1:0] e_xor;

    assign e_or  = a_q | b_q;
    assign e_and = a_q & b_q;
    assign e_xor = a_q ^ b_q;

    // Select both paths by op; inj corrupts only bit 0 of the NAND result
    always_comb begin
        s_d  = '0;
        sn_d = '0;
        unique case (op_q)
            OP_OR:   begin s_d = e_or;   sn_d = n_or;   end
            OP_NOR:  begin s_d = ~e_or;  sn_d = n_nor;  end
            OP_AND:  begin s_d = e_and;  sn_d = n_and;  end
            OP_NAND: begin s_d = ~e_and; sn_d = n_ab;   end
            OP_XOR:  begin s_d = e_xor;  sn_d = n_xor;  end
            OP_XNOR: begin s_d = ~e_xor; sn_d = n_xnor; end
            OP_NOTA: begin s_d = ~a_q;   sn_d = n_na;   end
            OP_PASS: begin s_d = a_q;    sn_d = n_pass; end
            default: begin s_d = '0;     sn_d = '0;     end
        endcase
        sn_d  = sn_d ^ WIDTH'(inj_q);
        mis_d = (s_d != sn_d);
    end

    // Stage 1: capture operands on input handshake, empty on transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            inj_q  <= 1'b0;
        end else if (in_hs) begin
            s1_v_q <= 1'b1;
            a_q    <= bus.a;
            b_q    <= bus.b;
            op_q   <= bus.op;
            inj_q  <= bus.inj;
        end else if (xfer) begin
            s1_v_q <= 1'b0;
        end
    end

    // Stage 2: register results on transfer, hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            s_q     <= '0;
            sn_q    <= '0;
            mis_q   <= 1'b0;
        end else if (xfer) begin
            out_v_q <= 1'b1;
            s_q     <= s_d;
            sn_q    <= sn_d;
            mis_q   <= mis_d;
        end else if (bus.out_ready) begin
            out_v_q <= 1'b0;
        end
    end

    // Counter next-state: clear beats a same-cycle output handshake
    always_comb begin
        txn_d = txn_q;
        err_d = err_q;
        if (bus.clear) begin
            txn_d = '0;
            err_d = '0;
        end else if (out_hs) begin
            txn_d = txn_q + 16'd1;
            if (mis_q && (err_q != {CNT_W{1'b1}})) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_q <= '0;
            err_q <= '0;
        end else begin
            txn_q <= txn_d;
            err_q <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_v_q;
    assign bus.s         = s_q;
    assign bus.s_nand    = sn_q;
    assign bus.mismatch  = mis_q;
    assign bus.txn_count = txn_q;
    assign bus.err_count = err_q;

endmodule
